// File: rtl/imem_loadable.sv
// Loadable synchronous-read instruction memory with a streaming load port.
// Define IMEM_MISALIGN_CHK_EN to flag fetches with fetch_pc[1:0] != 0 as errors.
module imem_loadable #(
   parameter int unsigned ADDR_WIDTH = 11,
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [31:0] BASE_ADDR  = 32'h0040_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fetch_req,
   input  logic [31:0]           fetch_pc,
   output logic                  fetch_valid,
   output logic [DATA_WIDTH-1:0] instruction,
   output logic                  fetch_err,
   output logic                  fetch_busy,
   input  logic                  load_start,
   input  logic                  load_valid,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  load_last,
   output logic                  load_ready,
   output logic [ADDR_WIDTH:0]   load_count,
   output logic                  load_ovf
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic {StRun, StLoad} state_e;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  mem_we;

   logic                  fetch_valid_q;
   logic [DATA_WIDTH-1:0] instruction_q;
   logic                  fetch_err_q;

   // Word offset from the text-segment base; the byte-lane bits are dropped here.
   logic [29:0]           word_off;
   logic [ADDR_WIDTH-1:0] rd_idx;
   logic                  rd_err;
   logic                  fetch_acc;

   assign word_off  = 30'((fetch_pc - BASE_ADDR) >> 2);
   assign rd_idx    = word_off[ADDR_WIDTH-1:0];
   assign fetch_acc = (state_q == StRun) && fetch_req;

   always_comb begin
      rd_err = (fetch_pc < BASE_ADDR) || (word_off[29:ADDR_WIDTH] != '0);
`ifdef IMEM_MISALIGN_CHK_EN
      rd_err = rd_err || (fetch_pc[1:0] != 2'b00);
`else
      rd_err = rd_err;
`endif
   end

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      ovf_d      = ovf_q;
      mem_we     = 1'b0;
      load_ready = 1'b0;
      fetch_busy = 1'b0;
      unique case (state_q)
         StRun: begin
            if (load_start) begin
               state_d  = StLoad;
               wr_ptr_d = '0;
               count_d  = '0;
               ovf_d    = 1'b0;
            end
         end
         StLoad: begin
            load_ready = 1'b1;
            fetch_busy = 1'b1;
            // A restart wins over a beat offered in the same cycle.
            if (load_start) begin
               wr_ptr_d = '0;
               count_d  = '0;
            end else if (load_valid) begin
               mem_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               count_d  = count_q + 1'b1;
               if (load_last) begin
                  state_d = StRun;
               end else if (wr_ptr_q == '1) begin
                  state_d = StRun;
                  ovf_d   = 1'b1;
               end
            end
         end
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StRun;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         ovf_q         <= 1'b0;
         fetch_valid_q <= 1'b0;
         instruction_q <= '0;
         fetch_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         ovf_q         <= ovf_d;
         fetch_valid_q <= fetch_acc;
         if (fetch_acc) begin
            instruction_q <= rd_err ? '0 : mem[rd_idx];
            fetch_err_q   <= rd_err;
         end
      end
   end

   // Array is deliberately not reset so programs survive rst.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem[wr_ptr_q] <= load_data;
      end
   end

   assign fetch_valid = fetch_valid_q;
   assign instruction = instruction_q;
   assign fetch_err   = fetch_err_q;
   assign load_count  = count_q;
   assign load_ovf    = ovf_q;

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench: default-size memory plus a 4-word instance sharing the same stimulus.
module tb_imem_loadable;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_req = 1'b0;
   logic [31:0] fetch_pc = 32'h0;
   logic        load_start = 1'b0;
   logic        load_valid = 1'b0;
   logic [31:0] load_data = 32'h0;
   logic        load_last = 1'b0;

   logic        fetch_valid, fetch_err, fetch_busy, load_ready, load_ovf;
   logic [31:0] instruction;
   logic [11:0] load_count;

   logic        s_fetch_valid, s_fetch_err, s_fetch_busy, s_load_ready, s_load_ovf;
   logic [31:0] s_instruction;
   logic [2:0]  s_load_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   imem_loadable dut (
      .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
      .fetch_valid(fetch_valid), .instruction(instruction), .fetch_err(fetch_err),
      .fetch_busy(fetch_busy), .load_start(load_start), .load_valid(load_valid),
      .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
      .load_count(load_count), .load_ovf(load_ovf)
   );

   imem_loadable #(.ADDR_WIDTH(2)) dut_small (
      .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
      .fetch_valid(s_fetch_valid), .instruction(s_instruction), .fetch_err(s_fetch_err),
      .fetch_busy(s_fetch_busy), .load_start(load_start), .load_valid(load_valid),
      .load_data(load_data), .load_last(load_last), .load_ready(s_load_ready),
      .load_count(s_load_count), .load_ovf(s_load_ovf)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        err;
   } vec_t;

   vec_t        vecs[7];
   logic [31:0] prog[4];

   initial begin
      prog[0] = 32'h2008_0001;
      prog[1] = 32'h2009_0002;
      prog[2] = 32'h0109_5020;
      prog[3] = 32'h0810_0000;
      vecs[0] = '{32'h0040_0000, 32'h2008_0001, 1'b0};
      vecs[1] = '{32'h0040_0004, 32'h2009_0002, 1'b0};
      vecs[2] = '{32'h0040_0008, 32'h0109_5020, 1'b0};
      vecs[3] = '{32'h0040_000C, 32'h0810_0000, 1'b0};
      vecs[4] = '{32'h003F_FFFC, 32'h0000_0000, 1'b1};
      vecs[5] = '{32'h0040_2000, 32'h0000_0000, 1'b1};
`ifdef IMEM_MISALIGN_CHK_EN
      vecs[6] = '{32'h0040_0002, 32'h0000_0000, 1'b1};
`else
      vecs[6] = '{32'h0040_0002, 32'h2008_0001, 1'b0};
`endif

      tick();
      tick();
      rst = 1'b0;
      check("rst fetch_valid", 32'(fetch_valid), 32'd0);
      check("rst instruction", instruction, 32'd0);
      check("rst fetch_err", 32'(fetch_err), 32'd0);
      check("rst fetch_busy", 32'(fetch_busy), 32'd0);
      check("rst load_ready", 32'(load_ready), 32'd0);
      check("rst load_count", 32'(load_count), 32'd0);
      check("rst load_ovf", 32'(load_ovf), 32'd0);

      // Four beats without load_last: small instance overflows, large stays in LOAD.
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      check("load_ready in load", 32'(load_ready), 32'd1);
      check("fetch_busy in load", 32'(fetch_busy), 32'd1);
      for (int i = 0; i < 4; i++) begin
         load_valid = 1'b1;
         load_data  = 32'h11 * (i + 1);
         fetch_req  = 1'b1;
         fetch_pc   = 32'h0040_0000;
         tick();
         check("no fetch_valid during load", 32'(fetch_valid), 32'd0);
      end
      load_valid = 1'b0;
      fetch_req  = 1'b0;
      check("small ovf", 32'(s_load_ovf), 32'd1);
      check("small count", 32'(s_load_count), 32'd4);
      check("small ready after ovf", 32'(s_load_ready), 32'd0);
      check("small busy after ovf", 32'(s_fetch_busy), 32'd0);
      check("big count mid load", 32'(load_count), 32'd4);
      check("big still loading", 32'(load_ready), 32'd1);
      check("big ovf", 32'(load_ovf), 32'd0);

      fetch_req = 1'b1;
      fetch_pc  = 32'h0040_0008;
      tick();
      fetch_req = 1'b0;
      check("small fetch valid", 32'(s_fetch_valid), 32'd1);
      check("small fetch data", s_instruction, 32'h33);
      check("small fetch err", 32'(s_fetch_err), 32'd0);
      check("big fetch ignored", 32'(fetch_valid), 32'd0);

      // Restart with a beat in the same cycle: beat must be dropped.
      load_start = 1'b1;
      load_valid = 1'b1;
      load_data  = 32'hDEAD_BEEF;
      tick();
      load_start = 1'b0;
      check("restart small ovf cleared", 32'(s_load_ovf), 32'd0);
      check("restart small count", 32'(s_load_count), 32'd0);
      check("restart big count", 32'(load_count), 32'd0);
      check("restart small ready", 32'(s_load_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         load_valid = 1'b1;
         load_data  = prog[i];
         load_last  = (i == 3);
         tick();
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      check("prog count", 32'(load_count), 32'd4);
      check("prog ovf", 32'(load_ovf), 32'd0);
      check("prog ready after last", 32'(load_ready), 32'd0);
      check("small last at full", 32'(s_load_ovf), 32'd0);

      // Back-to-back fetches from the vector table.
      for (int i = 0; i < 7; i++) begin
         fetch_req = 1'b1;
         fetch_pc  = vecs[i].pc;
         tick();
         check($sformatf("vec%0d valid", i), 32'(fetch_valid), 32'd1);
         check($sformatf("vec%0d instr", i), instruction, vecs[i].instr);
         check($sformatf("vec%0d err", i), 32'(fetch_err), 32'(vecs[i].err));
      end
      fetch_req = 1'b0;
      tick();
      check("valid drops", 32'(fetch_valid), 32'd0);
      check("instr holds", instruction, vecs[6].instr);

      // load_start with fetch in RUN, then reset mid-load.
      load_start = 1'b1;
      fetch_req  = 1'b1;
      fetch_pc   = 32'h0040_0004;
      tick();
      load_start = 1'b0;
      fetch_req  = 1'b0;
      check("start+fetch valid", 32'(fetch_valid), 32'd1);
      check("start+fetch data", instruction, 32'h2009_0002);
      check("start+fetch busy", 32'(fetch_busy), 32'd1);
      for (int i = 0; i < 2; i++) begin
         load_valid = 1'b1;
         load_data  = 32'hAAAA_0001 + i;
         tick();
      end
      load_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid rst ready", 32'(load_ready), 32'd0);
      check("mid rst count", 32'(load_count), 32'd0);
      check("mid rst busy", 32'(fetch_busy), 32'd0);
      check("mid rst instr", instruction, 32'd0);
      fetch_req = 1'b1;
      fetch_pc  = 32'h0040_0004;
      tick();
      fetch_pc  = 32'h0040_0008;
      tick();
      fetch_req = 1'b0;
      check("kept word idx2", instruction, 32'h0109_5020);
      check("kept word valid", 32'(fetch_valid), 32'd1);
      fetch_req = 1'b1;
      fetch_pc  = 32'h0040_0004;
      tick();
      fetch_req = 1'b0;
      check("after rst fetch", instruction, 32'hAAAA_0002);
      check("after rst err", 32'(fetch_err), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
